led_mode_seq: RTL and testbench

- Upstream stage of the 8-channel LED breathing/effect driver; produces the 4-bit `state` mode code that driver consumes.
- Debounces raw board pushbuttons and steps the mode code manually or on an auto-advance timer.
- Mode codes run 0..MAX_STATE with wrap-around.
- All outputs are registered, so the driver can sample `state` directly on `clk`.

---
 rtl/led_mode_seq.sv | 151 +++++++++++++++
 tb/tb_led_mode_seq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_mode_seq.sv
// led_mode_seq: debounced pushbutton mode sequencer with auto-advance timer.
// Macro LED_SEQ_PREV_EN builds the btn_prev path (backward stepping).

module led_seq_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_press
);
    localparam int            CW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] C_TC = CW'(DEBOUNCE_CYCLES);

    logic [1:0]    r_sync;
    logic          r_deb;
    logic          r_deb_d;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_deb_d <= r_deb;
            if (r_sync[1] == r_deb) begin
                r_cnt <= '0;
            end else if (r_cnt == C_TC) begin
                r_deb <= r_sync[1];
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Only the debounced rising edge is an event; release is silent.
    assign o_press = r_deb & ~r_deb_d;
endmodule

module led_mode_seq #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int AUTO_PERIOD     = 100000000,
    parameter int MAX_STATE       = 13
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       btn_auto,
    output logic [3:0] state,
    output logic       auto_on,
    output logic       step
);
    localparam int            TW         = $clog2(AUTO_PERIOD);
    localparam logic [TW-1:0] C_TMR_LAST = TW'(AUTO_PERIOD - 1);
    localparam logic [3:0]    C_MAX      = 4'(MAX_STATE);

    logic          w_ev_next;
    logic          w_ev_prev;
    logic          w_ev_auto;
    logic          w_manual;
    logic          w_tick;
    logic          w_do_next;
    logic [3:0]    w_state_nx;
    logic          w_step_nx;
    logic [TW-1:0] w_tmr_nx;

    logic [3:0]    r_state;
    logic          r_auto_on;
    logic          r_step;
    logic [TW-1:0] r_tmr;

    led_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_next (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (btn_next),
        .o_press (w_ev_next)
    );

    led_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_auto (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (btn_auto),
        .o_press (w_ev_auto)
    );

`ifdef LED_SEQ_PREV_EN
    logic w_do_prev;

    led_seq_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_prev (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_raw   (btn_prev),
        .o_press (w_ev_prev)
    );
`else
    // Pin kept for board compatibility; nothing behind it.
    logic w_unused_prev;
    assign w_unused_prev = btn_prev;
    assign w_ev_prev     = 1'b0;
`endif

    always_comb begin
        w_manual   = w_ev_next | w_ev_prev;
        w_tick     = r_auto_on && (r_tmr == C_TMR_LAST);
        // A manual request swallows a coincident auto tick.
        w_do_next  = (w_ev_next & ~w_ev_prev) | (w_tick & ~w_manual);
        w_state_nx = r_state;
        w_step_nx  = 1'b0;

        if (w_do_next) begin
            w_state_nx = (r_state == C_MAX) ? 4'd0 : r_state + 4'd1;
            w_step_nx  = 1'b1;
        end
`ifdef LED_SEQ_PREV_EN
        w_do_prev = w_ev_prev & ~w_ev_next;
        if (w_do_prev) begin
            w_state_nx = (r_state == 4'd0) ? C_MAX : r_state - 4'd1;
            w_step_nx  = 1'b1;
        end
`endif

        if (!r_auto_on || w_ev_auto || w_manual || w_tick) begin
            w_tmr_nx = '0;
        end else begin
            w_tmr_nx = r_tmr + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= 4'd0;
            r_auto_on <= 1'b0;
            r_step    <= 1'b0;
            r_tmr     <= '0;
        end else begin
            r_state   <= w_state_nx;
            r_auto_on <= r_auto_on ^ w_ev_auto;
            r_step    <= w_step_nx;
            r_tmr     <= w_tmr_nx;
        end
    end

    assign state   = r_state;
    assign auto_on = r_auto_on;
    assign step    = r_step;
endmodule

// File: tb/tb_led_mode_seq.sv
// Scoreboard bench for led_mode_seq: stimulus queues expected steps, a monitor checks them on step.
module tb_led_mode_seq;
    localparam int D   = 4;
    localparam int P   = 10;
    localparam int MX  = 13;
    // Drive on a negedge at cycle N -> step observed on the negedge at cycle N+LAT.
    localparam int LAT = D + 4;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_prev = 1'b0;
    logic       btn_auto = 1'b0;
    logic [3:0] state;
    logic       auto_on;
    logic       step;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int m_state  = 0;
    int m_auto   = 0;

    typedef struct {
        int st;
        int au;
        int cy;
    } exp_t;
    exp_t q[$];

    led_mode_seq #(
        .DEBOUNCE_CYCLES (D),
        .AUTO_PERIOD     (P),
        .MAX_STATE       (MX)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_next (btn_next),
        .btn_prev (btn_prev),
        .btn_auto (btn_auto),
        .state    (state),
        .auto_on  (auto_on),
        .step     (step)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic at(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic expect_step(input int st, input int au, input int cy);
        exp_t e;
        e.st = st;
        e.au = au;
        e.cy = cy;
        q.push_back(e);
    endtask

    function automatic int nxt(input int s);
        return (s == MX) ? 0 : s + 1;
    endfunction

    function automatic int prv(input int s);
        return (s == 0) ? MX : s - 1;
    endfunction

    task automatic press_next(input int hold);
        int c;
        c        = cyc;
        btn_next = 1'b1;
        m_state  = nxt(m_state);
        expect_step(m_state, m_auto, c + LAT);
        at(c + hold);
        btn_next = 1'b0;
        at(c + hold + 12);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("reset_state", int'(state), 0);
        chk("reset_auto", int'(auto_on), 0);
        chk("reset_step", int'(step), 0);
        m_state = 0;
        m_auto  = 0;
        at(cyc + 3);
        rst_n = 1'b1;
        at(cyc + 2);
    endtask

    // Monitor: pops one expectation per observed step pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (step === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_step state=%0d auto_on=%0d cycle=%0d", state, auto_on, cyc);
                end else begin
                    e = q.pop_front();
                    chk("step_cycle", cyc, e.cy);
                    chk("step_state", int'(state), e.st);
                    chk("step_auto", int'(auto_on), e.au);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout cycle=%0d required=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        repeat (3) @(negedge clk);
        chk("init_state", int'(state), 0);
        chk("init_auto", int'(auto_on), 0);
        chk("init_step", int'(step), 0);
        rst_n = 1'b1;
        at(cyc + 2);

        // Long hold: exactly one step, nothing on release.
        press_next(20);
        chk("hold_state", int'(state), 1);

        // Short glitches then a full wrap.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            btn_next = 1'b1;
            at(cyc + 2);
            btn_next = 1'b0;
            at(cyc + 8);
        end
        chk("glitch_state", int'(state), 0);
        for (int i = 0; i < 14; i++) press_next(6);
        chk("wrap_state", int'(state), 0);

        // Backward step (inert when the prev path is not built).
        c        = cyc;
        btn_prev = 1'b1;
`ifdef LED_SEQ_PREV_EN
        m_state = prv(m_state);
        expect_step(m_state, m_auto, c + LAT);
`endif
        at(c + 6);
        btn_prev = 1'b0;
        at(c + 18);
        chk("prev_state", int'(state), m_state);
        press_next(6);

        // Auto mode: three ticks, then off and frozen.
        c        = cyc;
        btn_auto = 1'b1;
        m_auto   = 1;
        for (int k = 1; k <= 3; k++) begin
            m_state = nxt(m_state);
            expect_step(m_state, 1, c + LAT + k * P);
        end
        at(c + 6);
        btn_auto = 1'b0;
        at(c + 7);
        chk("auto_on_before", int'(auto_on), 0);
        at(c + 8);
        chk("auto_on_after", int'(auto_on), 1);
        at(c + 32);
        btn_auto = 1'b1;
        at(c + 38);
        btn_auto = 1'b0;
        at(c + 39);
        chk("auto_off_before", int'(auto_on), 1);
        at(c + 40);
        chk("auto_off_after", int'(auto_on), 0);
        m_auto = 0;
        at(c + 90);
        chk("auto_frozen_state", int'(state), m_state);

        // Manual next colliding with a tick, then a manual step restarting the timer.
        c        = cyc;
        btn_auto = 1'b1;
        m_auto   = 1;
        m_state  = nxt(m_state);
        expect_step(m_state, 1, c + 18);
        m_state = nxt(m_state);
        expect_step(m_state, 1, c + 28);
        m_state = nxt(m_state);
        expect_step(m_state, 1, c + 33);
        m_state = nxt(m_state);
        expect_step(m_state, 1, c + 43);
        at(c + 6);
        btn_auto = 1'b0;
        at(c + 10);
        btn_next = 1'b1;
        at(c + 16);
        btn_next = 1'b0;
        at(c + 25);
        btn_next = 1'b1;
        at(c + 31);
        btn_next = 1'b0;
        at(c + 36);
        btn_auto = 1'b1;
        at(c + 42);
        btn_auto = 1'b0;
        at(c + 45);
        chk("collide_auto_off", int'(auto_on), 0);
        m_auto = 0;
        at(c + 50);

        // next and prev debounced together.
        c        = cyc;
        btn_next = 1'b1;
        btn_prev = 1'b1;
`ifndef LED_SEQ_PREV_EN
        m_state = nxt(m_state);
        expect_step(m_state, m_auto, c + LAT);
`endif
        at(c + 6);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        at(c + 20);
        chk("both_state", int'(state), m_state);

        // Reset mid-debounce at state 5 with auto on, button held through reset.
        while (m_state != 5) press_next(6);
        c        = cyc;
        btn_auto = 1'b1;
        m_auto   = 1;
        at(c + 6);
        btn_auto = 1'b0;
        at(c + 8);
        chk("pre_reset_auto", int'(auto_on), 1);
        at(c + 10);
        btn_next = 1'b1;
        at(c + 12);
        rst_n = 1'b0;
        #1;
        chk("midreset_state", int'(state), 0);
        chk("midreset_auto", int'(auto_on), 0);
        chk("midreset_step", int'(step), 0);
        m_state = 0;
        m_auto  = 0;
        at(c + 15);
        rst_n   = 1'b1;
        m_state = 1;
        expect_step(m_state, 0, c + 15 + LAT);
        at(c + 30);
        btn_next = 1'b0;
        at(c + 45);
        chk("post_reset_state", int'(state), 1);
        chk("post_reset_auto", int'(auto_on), 0);

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
